// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection controller: head lamp codes,
// sequencer state encoding and road identifiers.
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b001;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        WALK    = 2'd3
    } state_e;

    // Lamp code for one head; a head that is not being served is always red.
    function automatic logic [2:0] head_light(input state_e st, input logic served);
        logic [2:0] lamp;
        lamp = LIGHT_RED;
        if (served) begin
            case (st)
                GREEN:   lamp = LIGHT_GREEN;
                YELLOW:  lamp = LIGHT_YELLOW;
                default: lamp = LIGHT_RED;
            endcase
        end else begin
            lamp = LIGHT_RED;
        end
        return lamp;
    endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// Sensor/request inputs and lamp/status outputs of the intersection controller.
interface intersection_controller_if;

    logic       tick;
    logic       ns_car;
    logic       ew_car;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
        output tick, ns_car, ew_car, ped_req,
        input  ns_light, ew_light, walk, ped_ack, phase
    );

    modport slave (
        input  tick, ns_car, ew_car, ped_req,
        output ns_light, ew_light, walk, ped_ack, phase
    );

endinterface

// File: rtl/intersection_controller_phase_timer.sv
// Tick-enabled phase timer: synchronous clear, saturation limit and a
// done flag that fires on the tick that completes the programmed duration.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             clr,
    input  logic [CNT_W-1:0] sat_lim,
    input  logic [CNT_W-1:0] done_val,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: clear dominates, otherwise advance on tick until the limit.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CNT_W{1'b0}};
        end else if (tick && (count_q < sat_lim)) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = tick && (count_q == done_val);

endmodule

// File: rtl/intersection_controller.sv
// Actuated NS/EW intersection sequencer with min/max green, yellow,
// all-red clearance and an exclusive pedestrian WALK phase.
module intersection_controller
    import traffic_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    intersection_controller_if.slave bus
);

    if (GREEN_MIN < 1 || GREEN_MAX < 1 || YELLOW_T < 1 || ALLRED_T < 1 || WALK_T < 1)
    begin : g_bad_duration
        $error("intersection_controller: every duration must be at least one tick");
    end
    if (GREEN_MAX < GREEN_MIN) begin : g_bad_green
        $error("intersection_controller: GREEN_MAX must not be below GREEN_MIN");
    end
    if (GREEN_MAX >= (2 ** CNT_W) || WALK_T >= (2 ** CNT_W)) begin : g_bad_width
        $error("intersection_controller: durations do not fit the timer width");
    end

    localparam logic [CNT_W-1:0] GMIN_M1   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1   = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1 = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_M1   = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] TMR_TOP   = {CNT_W{1'b1}};

    state_e           state_d, state_q;
    logic             dir_d, dir_q;
    logic             ped_pend_d, ped_pend_q;
    logic [2:0]       ns_light_d, ns_light_q;
    logic [2:0]       ew_light_d, ew_light_q;
    logic             walk_d, walk_q;
    logic             ped_ack_d, ped_ack_q;
    logic [2:0]       phase_d, phase_q;

    logic             own_s, opp_s, dem_s;
    logic             walk_enter_s;
    logic             tmr_clr_s, tmr_done_s;
    logic [CNT_W-1:0] tmr_sat_s, tmr_done_val_s, timer_s;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (bus.tick),
        .clr      (tmr_clr_s),
        .sat_lim  (tmr_sat_s),
        .done_val (tmr_done_val_s),
        .count    (timer_s),
        .done     (tmr_done_s)
    );

    // Timer programming: duration of the current state, saturation only in GREEN.
    always_comb begin
        tmr_sat_s      = TMR_TOP;
        tmr_done_val_s = ALLRED_M1;
        case (state_q)
            ALL_RED: tmr_done_val_s = ALLRED_M1;
            GREEN: begin
                tmr_done_val_s = GMAX_M1;
                tmr_sat_s      = GMAX_M1;
            end
            YELLOW:  tmr_done_val_s = YELLOW_M1;
            WALK:    tmr_done_val_s = WALK_M1;
            default: tmr_done_val_s = ALLRED_M1;
        endcase
        tmr_clr_s = (state_d != state_q);
    end

    // Next-state logic: every transition is qualified by the timer's tick.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        walk_enter_s = 1'b0;
        own_s        = (dir_q == DIR_EW) ? bus.ew_car : bus.ns_car;
        opp_s        = (dir_q == DIR_EW) ? bus.ns_car : bus.ew_car;
        dem_s        = opp_s | ped_pend_q;
        case (state_q)
            ALL_RED: begin
                if (tmr_done_s && ped_pend_q) begin
                    state_d      = WALK;
                    walk_enter_s = 1'b1;
                end else if (tmr_done_s) begin
                    state_d = GREEN;
                    dir_d   = ~dir_q;
                end else begin
                    state_d = ALL_RED;
                end
            end
            GREEN: begin
                // Gap-out when own road is empty, max-out once the timer saturates.
                if (bus.tick && (timer_s >= GMIN_M1) && dem_s && (!own_s || tmr_done_s)) begin
                    state_d = YELLOW;
                end else begin
                    state_d = GREEN;
                end
            end
            YELLOW: begin
                if (tmr_done_s) begin
                    state_d = ALL_RED;
                end else begin
                    state_d = YELLOW;
                end
            end
            WALK: begin
                if (tmr_done_s) begin
                    state_d = GREEN;
                    dir_d   = ~dir_q;
                end else begin
                    state_d = WALK;
                end
            end
            default: begin
                state_d = ALL_RED;
                dir_d   = DIR_EW;
            end
        endcase

        // Entering WALK consumes the request; a request on that same cycle is absorbed.
        if (walk_enter_s) begin
            ped_pend_d = 1'b0;
        end else if (bus.ped_req && (state_q != WALK)) begin
            ped_pend_d = 1'b1;
        end else begin
            ped_pend_d = ped_pend_q;
        end
    end

    // Output decode from the next state so the registered outputs track the state flops.
    always_comb begin
        ns_light_d = head_light(state_d, dir_d == DIR_NS);
        ew_light_d = head_light(state_d, dir_d == DIR_EW);
        walk_d     = (state_d == WALK);
        ped_ack_d  = walk_enter_s;
        phase_d    = {dir_d, state_d};
    end

    // State and output registers; reset forces all-red immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ALL_RED;
            dir_q      <= DIR_EW;
            ped_pend_q <= 1'b0;
            ns_light_q <= LIGHT_RED;
            ew_light_q <= LIGHT_RED;
            walk_q     <= 1'b0;
            ped_ack_q  <= 1'b0;
            phase_q    <= 3'b100;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            ped_pend_q <= ped_pend_d;
            ns_light_q <= ns_light_d;
            ew_light_q <= ew_light_d;
            walk_q     <= walk_d;
            ped_ack_q  <= ped_ack_d;
            phase_q    <= phase_d;
        end
    end

    assign bus.ns_light = ns_light_q;
    assign bus.ew_light = ew_light_q;
    assign bus.walk     = walk_q;
    assign bus.ped_ack  = ped_ack_q;
    assign bus.phase    = phase_q;

endmodule
